sprite_blitter: RTL and testbench

- Reader side of the sprite ROMs: walks an SPR_W x SPR_H sprite ROM that has 1-cycle registered read latency and 5-bit palette-index data.
- Writes each non-transparent pixel to the framebuffer write port at screen position (x0+col, y0+row).
- Sits between the game-state FSM, which requests draws, and the framebuffer/VGA pipeline, which accepts pixel writes with backpressure.

---
 rtl/sprite_blitter.sv | 180 ++++++++++++++++++
 tb/tb_sprite_blitter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_blitter.sv
// sprite_blitter: walks a registered-read sprite ROM and writes non-transparent, on-screen pixels
// to a backpressured framebuffer port. Define SPRITE_BLITTER_HFLIP_EN to add a latched hflip input.
module sprite_blitter #(
    parameter int SPR_W  = 150,
    parameter int SPR_H  = 120,
    parameter int ADDR_W = 15,
    parameter int PIX_W  = 5,
    parameter int SCR_W  = 640,
    parameter int SCR_H  = 480,
    parameter int TRANSP = 0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic [9:0]        x0,
    input  logic [9:0]        y0,
`ifdef SPRITE_BLITTER_HFLIP_EN
    input  logic              hflip,
`endif
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [PIX_W-1:0]  rom_data,
    output logic              fb_we,
    output logic [9:0]        fb_x,
    output logic [9:0]        fb_y,
    output logic [PIX_W-1:0]  fb_data,
    input  logic              fb_ready
);
    localparam int COL_W = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int ROW_W = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(SPR_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(SPR_H - 1);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_CAPT, S_WRITE, S_DONE} state_t;

    state_t             state_reg, state_next;
    logic [COL_W-1:0]   col_reg, col_next;
    logic [ROW_W-1:0]   row_reg, row_next;
    logic [9:0]         x0_reg, x0_next, y0_reg, y0_next;
    logic [ADDR_W-1:0]  addr_reg, addr_next;
    logic               we_reg, we_next;
    logic [9:0]         fbx_reg, fbx_next, fby_reg, fby_next;
    logic [PIX_W-1:0]   fbd_reg, fbd_next;
    logic               accept, advance, step;
    logic [10:0]        x_sum, y_sum;
`ifdef SPRITE_BLITTER_HFLIP_EN
    logic               hflip_reg, hflip_next;
    logic [ADDR_W-1:0]  row_base_reg, row_base_next;
`endif

    // Sums kept at 11 bits so an off-screen origin near 1023 cannot wrap back on-screen.
    assign x_sum = {1'b0, x0_reg} + 11'(col_reg);
    assign y_sum = {1'b0, y0_reg} + 11'(row_reg);

    always_comb begin
        state_next = state_reg;
        col_next   = col_reg;
        row_next   = row_reg;
        x0_next    = x0_reg;
        y0_next    = y0_reg;
        addr_next  = addr_reg;
        we_next    = we_reg;
        fbx_next   = fbx_reg;
        fby_next   = fby_reg;
        fbd_next   = fbd_reg;
        accept     = 1'b0;
        advance    = 1'b0;
        step       = 1'b0;
`ifdef SPRITE_BLITTER_HFLIP_EN
        hflip_next    = hflip_reg;
        row_base_next = row_base_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    x0_next    = x0;
                    y0_next    = y0;
                    col_next   = '0;
                    row_next   = '0;
                    state_next = S_ADDR;
`ifdef SPRITE_BLITTER_HFLIP_EN
                    hflip_next    = hflip;
                    row_base_next = '0;
`endif
                end
            end
            S_ADDR: state_next = S_CAPT;
            S_CAPT: begin
                fbd_next = rom_data;
                fbx_next = x_sum[9:0];
                fby_next = y_sum[9:0];
                if (rom_data == PIX_W'(TRANSP) || x_sum >= 11'(SCR_W) || y_sum >= 11'(SCR_H)) begin
                    advance = 1'b1;
                end else begin
                    we_next    = 1'b1;
                    state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                if (fb_ready) begin
                    we_next = 1'b0;
                    advance = 1'b1;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase

        if (advance) begin
            if (col_reg != COL_LAST) begin
                col_next   = col_reg + COL_W'(1);
                state_next = S_ADDR;
            end else if (row_reg != ROW_LAST) begin
                col_next   = '0;
                row_next   = row_reg + ROW_W'(1);
                state_next = S_ADDR;
            end else begin
                state_next = S_DONE;
            end
        end
        step = advance && (state_next == S_ADDR);

`ifdef SPRITE_BLITTER_HFLIP_EN
        // row_base tracks row*SPR_W so the mirrored column needs only an add, never a multiply.
        if (step && col_reg == COL_LAST)
            row_base_next = row_base_reg + ADDR_W'(SPR_W);
        if (accept || step)
            addr_next = row_base_next + (hflip_next ? ADDR_W'(COL_LAST - col_next) : ADDR_W'(col_next));
`else
        if (accept)
            addr_next = '0;
        else if (step)
            addr_next = addr_reg + ADDR_W'(1);
`endif
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg <= S_IDLE;
            col_reg   <= '0;
            row_reg   <= '0;
            x0_reg    <= '0;
            y0_reg    <= '0;
            addr_reg  <= '0;
            we_reg    <= 1'b0;
            fbx_reg   <= '0;
            fby_reg   <= '0;
            fbd_reg   <= '0;
`ifdef SPRITE_BLITTER_HFLIP_EN
            hflip_reg    <= 1'b0;
            row_base_reg <= '0;
`endif
        end else begin
            state_reg <= state_next;
            col_reg   <= col_next;
            row_reg   <= row_next;
            x0_reg    <= x0_next;
            y0_reg    <= y0_next;
            addr_reg  <= addr_next;
            we_reg    <= we_next;
            fbx_reg   <= fbx_next;
            fby_reg   <= fby_next;
            fbd_reg   <= fbd_next;
`ifdef SPRITE_BLITTER_HFLIP_EN
            hflip_reg    <= hflip_next;
            row_base_reg <= row_base_next;
`endif
        end
    end

    assign busy     = (state_reg == S_ADDR) || (state_reg == S_CAPT) || (state_reg == S_WRITE);
    assign done     = (state_reg == S_DONE);
    assign rom_addr = addr_reg;
    assign fb_we    = we_reg;
    assign fb_x     = fbx_reg;
    assign fb_y     = fby_reg;
    assign fb_data  = fbd_reg;
endmodule

// File: tb/tb_sprite_blitter.sv
// Testbench for sprite_blitter: 4x3 sprite, directed scenarios plus randomized draws against a
// raster-order reference model of the expected framebuffer writes.
`timescale 1ns/1ps
module tb_sprite_blitter;
    localparam int W = 4;
    localparam int H = 3;
    localparam int N = W * H;

    logic        Clk = 1'b0;
    logic        Reset, start;
    logic [9:0]  x0, y0;
`ifdef SPRITE_BLITTER_HFLIP_EN
    logic        hflip;
`endif
    logic        busy, done;
    logic [14:0] rom_addr;
    logic [4:0]  rom_data;
    logic        fb_we;
    logic [9:0]  fb_x, fb_y;
    logic [4:0]  fb_data;
    logic        fb_ready;

    logic [4:0]  rom [0:N-1];
    int          checks = 0;
    int          errors = 0;

    typedef struct {int x; int y; int d; int a;} wr_t;
    wr_t exp_q[$];
    int  exp_skips;
    int  exp_last_addr;

    sprite_blitter #(
        .SPR_W(W), .SPR_H(H), .ADDR_W(15), .PIX_W(5),
        .SCR_W(640), .SCR_H(480), .TRANSP(0)
    ) dut (
        .Clk(Clk), .Reset(Reset), .start(start), .x0(x0), .y0(y0),
`ifdef SPRITE_BLITTER_HFLIP_EN
        .hflip(hflip),
`endif
        .busy(busy), .done(done), .rom_addr(rom_addr), .rom_data(rom_data),
        .fb_we(fb_we), .fb_x(fb_x), .fb_y(fb_y), .fb_data(fb_data), .fb_ready(fb_ready)
    );

    always #5 Clk = ~Clk;

    // Sprite ROM with one cycle of registered read latency.
    always @(posedge Clk)
        rom_data <= (rom_addr < 15'(N)) ? rom[rom_addr[3:0]] : 5'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Expected writes: every pixel in raster order, mirrored ROM column when flipped,
    // dropped if transparent or off-screen.
    task automatic build_model(input int x0v, input int y0v, input int hf);
        exp_q.delete();
        exp_skips = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                int a;
                int x;
                int y;
                a = r * W + ((hf != 0) ? (W - 1 - c) : c);
                x = x0v + c;
                y = y0v + r;
                if (rom[a] != 5'd0 && x < 640 && y < 480)
                    exp_q.push_back('{x, y, int'(rom[a]), a});
                else
                    exp_skips++;
            end
        end
        exp_last_addr = (H - 1) * W + ((hf != 0) ? 0 : W - 1);
    endtask

    task automatic run_draw(input string name, input int x0v, input int y0v, input int hf,
                            input int rnd_ready, input int stall_at, input int stall_len,
                            input int rst_at, input int restart_at);
        int         widx;
        int         cyc;
        int         stall_left;
        int         got_done;
        bit         in_write;
        logic [9:0] hx, hy;
        logic [4:0] hd;
        widx = 0; stall_left = 0; got_done = 0; in_write = 0;
        hx = '0; hy = '0; hd = '0;
        build_model(x0v, y0v, hf);

        start = 1'b1;
        x0 = 10'(x0v);
        y0 = 10'(y0v);
`ifdef SPRITE_BLITTER_HFLIP_EN
        hflip = 1'(hf);
`endif
        cyc = 1;
        @(posedge Clk); #1;
        cyc = 2;
        start = 1'b0;
        x0 = 10'($urandom);
        y0 = 10'($urandom);
`ifdef SPRITE_BLITTER_HFLIP_EN
        hflip = ~hflip;
`endif
        chk({name, " busy_after_start"}, busy, 1);

        for (int n = 0; n < 400 && got_done == 0; n++) begin
            start = 1'b0;
            if (done) begin
                got_done = 1;
                chk({name, " busy_in_done"}, busy, 0);
                chk({name, " write_count"}, widx, exp_q.size());
                chk({name, " final_rom_addr"}, rom_addr, exp_last_addr);
                if (rnd_ready == 0)
                    chk({name, " done_cycle"}, cyc, 1 + 3 * exp_q.size() + 2 * exp_skips + stall_len + 1);
                fb_ready = 1'b0;
            end else if (fb_we) begin
                if (!in_write) begin
                    in_write = 1'b1;
                    if (widx < exp_q.size()) begin
                        chk({name, " fb_x"}, fb_x, exp_q[widx].x);
                        chk({name, " fb_y"}, fb_y, exp_q[widx].y);
                        chk({name, " fb_data"}, fb_data, exp_q[widx].d);
                        chk({name, " rom_addr"}, rom_addr, exp_q[widx].a);
                    end else begin
                        chk({name, " extra_write"}, widx, exp_q.size());
                    end
                    chk({name, " busy_in_write"}, busy, 1);
                    hx = fb_x; hy = fb_y; hd = fb_data;
                    stall_left = (widx == stall_at) ? stall_len : 0;
                    if (widx == restart_at) begin
                        start = 1'b1;
                        x0 = 10'd0;
                        y0 = 10'd0;
                    end
                    if (widx == rst_at) begin
                        Reset = 1'b1;
                        fb_ready = 1'b0;
                        @(posedge Clk); #1;
                        Reset = 1'b0;
                        chk({name, " reset_fb_we"}, fb_we, 0);
                        chk({name, " reset_busy"}, busy, 0);
                        chk({name, " reset_done"}, done, 0);
                        chk({name, " reset_rom_addr"}, rom_addr, 0);
                        for (int k = 0; k < 5; k++) begin
                            @(posedge Clk); #1;
                            chk({name, " no_done_after_reset"}, done, 0);
                        end
                        return;
                    end
                end else begin
                    chk({name, " hold_x"}, fb_x, hx);
                    chk({name, " hold_y"}, fb_y, hy);
                    chk({name, " hold_data"}, fb_data, hd);
                end
                if (stall_left > 0) begin
                    fb_ready = 1'b0;
                    stall_left--;
                end else begin
                    fb_ready = (rnd_ready != 0) ? 1'($urandom) : 1'b1;
                end
                if (fb_ready) begin
                    widx++;
                    in_write = 1'b0;
                end
            end else begin
                fb_ready = 1'($urandom);
            end
            @(posedge Clk); #1;
            cyc++;
        end
        chk({name, " done_seen"}, got_done, 1);
        chk({name, " done_one_cycle"}, done, 0);
        chk({name, " idle_busy"}, busy, 0);
        $display("%s: x0=%0d y0=%0d hflip=%0d writes=%0d skips=%0d", name, x0v, y0v, hf, widx, exp_skips);
    endtask

    initial begin
        int hf;
        Reset = 1'b1; start = 1'b0; x0 = '0; y0 = '0; fb_ready = 1'b0;
`ifdef SPRITE_BLITTER_HFLIP_EN
        hflip = 1'b0;
`endif
        for (int i = 0; i < N; i++) rom[i] = 5'(i + 1);
        repeat (2) @(posedge Clk);
        #1;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset fb_we", fb_we, 0);
        chk("reset rom_addr", rom_addr, 0);
        chk("reset fb_x", fb_x, 0);
        chk("reset fb_y", fb_y, 0);
        chk("reset fb_data", fb_data, 0);
        Reset = 1'b0;
        @(posedge Clk); #1;
        chk("idle busy", busy, 0);

        run_draw("basic", 10, 20, 0, 0, -1, 0, -1, -1);

        rom[2] = 5'd0; rom[5] = 5'd0;
        run_draw("transparent", 10, 20, 0, 0, -1, 0, -1, -1);
        rom[2] = 5'd3; rom[5] = 5'd6;

        run_draw("clip", 638, 478, 0, 0, -1, 0, -1, -1);
        run_draw("clip_far", 1022, 20, 0, 0, -1, 0, -1, -1);
        run_draw("backpressure", 10, 20, 0, 0, 2, 5, -1, -1);
        run_draw("reset_mid", 10, 20, 0, 0, -1, 0, 5, -1);
        run_draw("after_reset", 10, 20, 0, 0, -1, 0, -1, -1);
        run_draw("start_busy", 10, 20, 0, 0, -1, 0, -1, 4);
`ifdef SPRITE_BLITTER_HFLIP_EN
        run_draw("hflip", 10, 20, 1, 0, -1, 0, -1, -1);
`endif

        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < N; i++)
                rom[i] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
`ifdef SPRITE_BLITTER_HFLIP_EN
            hf = int'($urandom_range(0, 1));
`else
            hf = 0;
`endif
            run_draw("random", int'($urandom_range(600, 660)), int'($urandom_range(470, 490)),
                     hf, 1, int'($urandom_range(0, 6)), int'($urandom_range(0, 4)), -1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
